// File: rtl/tetris_defs_pkg.sv
// Shared action and button encodings for the Tetris input path.
// Button codes match the NES input controller; action codes match the grid controller.
package tetris_defs;

  localparam logic [2:0] ACT_NONE      = 3'd0;
  localparam logic [2:0] ACT_LEFT      = 3'd1;
  localparam logic [2:0] ACT_RIGHT     = 3'd2;
  localparam logic [2:0] ACT_SOFT_DROP = 3'd3;
  localparam logic [2:0] ACT_ROT_CW    = 3'd4;
  localparam logic [2:0] ACT_ROT_CCW   = 3'd5;
  localparam logic [2:0] ACT_HARD_DROP = 3'd6;
  localparam logic [2:0] ACT_GRAVITY   = 3'd7;

  localparam logic [3:0] BTN_NONE   = 4'd0;
  localparam logic [3:0] BTN_A      = 4'd1;
  localparam logic [3:0] BTN_B      = 4'd2;
  localparam logic [3:0] BTN_SELECT = 4'd3;
  localparam logic [3:0] BTN_START  = 4'd4;
  localparam logic [3:0] BTN_UP     = 4'd5;
  localparam logic [3:0] BTN_DOWN   = 4'd6;
  localparam logic [3:0] BTN_LEFT   = 4'd7;
  localparam logic [3:0] BTN_RIGHT  = 4'd8;

  // SELECT and START never become grid actions.
  function automatic logic [2:0] button_to_action(input logic [3:0] code);
    case (code)
      BTN_A:     return ACT_ROT_CW;
      BTN_B:     return ACT_ROT_CCW;
      BTN_UP:    return ACT_HARD_DROP;
      BTN_DOWN:  return ACT_SOFT_DROP;
      BTN_LEFT:  return ACT_LEFT;
      BTN_RIGHT: return ACT_RIGHT;
      default:   return ACT_NONE;
    endcase
  endfunction

  function automatic logic is_auto_repeat(input logic [3:0] code);
    return (code == BTN_LEFT) || (code == BTN_RIGHT) || (code == BTN_DOWN);
  endfunction

endpackage

// File: rtl/tetris_press_tracker.sv
// Press tracker: turns the level-coded button stream into press and auto-repeat
// event pulses, ignoring short all-zero gaps from the controller's per-frame latch clear.
module tetris_press_tracker
  import tetris_defs::*;
#(
  parameter int RELEASE_CYCLES = 8192,
  parameter int DAS_DELAY      = 800000,
  parameter int DAS_PERIOD     = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button_code,
  output logic       event_pulse,
  output logic       event_repeat,
  output logic [3:0] event_code
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_HELD   = 2'd3;

  localparam int DAS_MAX = (DAS_DELAY > DAS_PERIOD) ? DAS_DELAY : DAS_PERIOD;
  localparam int ZW      = $clog2(RELEASE_CYCLES + 1);
  localparam int DW      = $clog2(DAS_MAX + 1);

  logic [1:0]    state;
  logic [3:0]    tracked;
  logic [ZW-1:0] zero_cnt;
  logic [DW-1:0] das_cnt;
  logic          new_press;
  logic          released;
  logic          das_hit;

  always_comb begin
    new_press    = (button_code != BTN_NONE) && ((state == ST_IDLE) || (button_code != tracked));
    released     = (state != ST_IDLE) && (button_code == BTN_NONE) &&
                   (zero_cnt >= ZW'(RELEASE_CYCLES));
    das_hit      = ((state == ST_FIRST)  && (das_cnt == DW'(DAS_DELAY))) ||
                   ((state == ST_REPEAT) && (das_cnt == DW'(DAS_PERIOD)));
    event_pulse  = new_press || (das_hit && !released);
    event_repeat = !new_press;
    event_code   = new_press ? button_code : tracked;
  end

  // NOTE: synchronous reset is the first branch of the clocked block, and all
  // state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tracked  <= BTN_NONE;
      zero_cnt <= '0;
      das_cnt  <= '0;
    end else if (new_press) begin
      // das_cnt starts at 1 so the first repeat lands exactly DAS_DELAY cycles after the press.
      tracked  <= button_code;
      zero_cnt <= '0;
      das_cnt  <= DW'(1);
      state    <= is_auto_repeat(button_code) ? ST_FIRST : ST_HELD;
    end else if (released) begin
      state    <= ST_IDLE;
      tracked  <= BTN_NONE;
      zero_cnt <= '0;
      das_cnt  <= '0;
    end else if (state != ST_IDLE) begin
      zero_cnt <= (button_code == BTN_NONE) ? zero_cnt + 1'b1 : '0;
      if (das_hit) begin
        state   <= ST_REPEAT;
        das_cnt <= DW'(1);
      end else if (state != ST_HELD) begin
        das_cnt <= das_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_action_scheduler.sv
// Action scheduler: gravity timer, user/gravity pending flags, round-robin arbiter
// and the valid/ready action register feeding the grid controller.
module tetris_action_scheduler
  import tetris_defs::*;
#(
  parameter int RELEASE_CYCLES = 8192,
  parameter int DAS_DELAY      = 800000,
  parameter int DAS_PERIOD     = 250000,
  parameter int GRAVITY_BASE   = 40000000,
  parameter int GRAVITY_STEP   = 3500000,
  parameter int GRAVITY_MIN    = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button_code,
  input  logic [3:0] level,
  input  logic       game_over,
  input  logic       action_ready,
  output logic       action_valid,
  output logic [2:0] action,
  output logic       paused
);

  localparam logic [31:0] BASE_U = 32'(GRAVITY_BASE);
  localparam logic [31:0] STEP_U = 32'(GRAVITY_STEP);
  localparam logic [31:0] MIN_U  = 32'(GRAVITY_MIN);
  localparam logic [31:0] SPAN_U = BASE_U - MIN_U;

  logic        ev_pulse;
  logic        ev_repeat;
  logic [3:0]  ev_code;
  logic [2:0]  ev_action;
  logic        frozen;
  logic        start_evt;
  logic        accept_evt;
  logic        fire;
  logic        pick_user;
  logic        grav_expire;
  logic [31:0] level_step;
  logic [31:0] grav_period;
  logic [31:0] grav_cnt;
  logic [31:0] grav_cnt_inc;
  logic        user_pend;
  logic        user_renew;
  logic [2:0]  user_action;
  logic        grav_pend;
  logic        granted_user;
  logic        last_user;

  tetris_press_tracker #(
    .RELEASE_CYCLES (RELEASE_CYCLES),
    .DAS_DELAY      (DAS_DELAY),
    .DAS_PERIOD     (DAS_PERIOD)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .button_code  (button_code),
    .event_pulse  (ev_pulse),
    .event_repeat (ev_repeat),
    .event_code   (ev_code)
  );

  always_comb begin
    frozen       = paused || game_over;
    ev_action    = button_to_action(ev_code);
    start_evt    = ev_pulse && (ev_code == BTN_START);
    // A repeat only fills an empty slot; a fresh press always overwrites it.
    accept_evt   = ev_pulse && (ev_action != ACT_NONE) && !frozen && (!ev_repeat || !user_pend);
    level_step   = 32'(level) * STEP_U;
    grav_period  = (level_step >= SPAN_U) ? MIN_U : BASE_U - level_step;
    grav_cnt_inc = grav_cnt + 32'd1;
    grav_expire  = !frozen && (grav_cnt_inc >= grav_period);
    fire         = action_valid && action_ready;
    pick_user    = user_pend && (!grav_pend || !last_user);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paused       <= 1'b0;
      action_valid <= 1'b0;
      action       <= ACT_NONE;
      grav_cnt     <= '0;
      user_pend    <= 1'b0;
      user_renew   <= 1'b0;
      user_action  <= ACT_NONE;
      grav_pend    <= 1'b0;
      granted_user <= 1'b0;
      last_user    <= 1'b0;
    end else begin
      if (start_evt) paused <= !paused;
      if (!frozen) grav_cnt <= grav_expire ? '0 : grav_cnt_inc;

      if (fire) begin
        action_valid <= 1'b0;
        action       <= ACT_NONE;
      end else if (!action_valid && !frozen && (user_pend || grav_pend)) begin
        action_valid <= 1'b1;
        action       <= pick_user ? user_action : ACT_GRAVITY;
        granted_user <= pick_user;
        last_user    <= pick_user;
      end

      // Pending flags stay set while their action is on the port, so expiries
      // during a stall are absorbed; user_renew remembers a press that arrived meanwhile.
      if (frozen) begin
        user_pend  <= 1'b0;
        user_renew <= 1'b0;
        grav_pend  <= 1'b0;
      end else begin
        if (fire && !granted_user) grav_pend <= 1'b0;
        else if (grav_expire)      grav_pend <= 1'b1;
        if (fire && granted_user) begin
          user_pend  <= user_renew;
          user_renew <= 1'b0;
        end
        if (accept_evt) begin
          user_pend   <= 1'b1;
          user_action <= ev_action;
          user_renew  <= action_valid && granted_user && !fire;
        end
      end
    end
  end

endmodule
